// File: rtl/addr_decode_ws.sv
// addr_decode_ws: bus address decoder with per-region wait states.
// A falling edge on AS (in IDLE) starts an access. The access either selects one
// region, inserts its wait states and acknowledges, or times out with a bus error.
// One region doubles as a 2-bit control register {WOCO,BK4} that qualifies decoding.
module addr_decode_ws #(
    parameter int                  AW        = 16,
    parameter int                  NREG      = 4,
    parameter int                  WSW       = 3,
    parameter logic [NREG*AW-1:0]  BASE      = {16'h5C00, 16'h2000, 16'h2000, 16'h8000},
    parameter logic [NREG*AW-1:0]  MASK      = {16'hFC00, 16'hE000, 16'hE000, 16'h8000},
    parameter logic [NREG*2-1:0]   QMASK     = {2'b00, 2'b01, 2'b01, 2'b00},
    parameter logic [NREG*2-1:0]   QVAL      = {2'b00, 2'b00, 2'b01, 2'b00},
    parameter logic [NREG*WSW-1:0] WS        = {3'd2, 3'd1, 3'd0, 3'd0},
    parameter int                  CTRL_REG  = 3,
    parameter logic [1:0]          CTRL_INIT = 2'b00,
    parameter int                  TOUT      = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            AS,
    input  logic            RW,
    input  logic [AW-1:0]   ADDR,
    input  logic [7:0]      DIN,
    output logic [NREG-1:0] CS_N,
    output logic            RDY,
    output logic            BERR,
    output logic [1:0]      CTRL
);

    localparam int                SELW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [SELW-1:0]   CTRL_SEL = SELW'(CTRL_REG);
    localparam logic [7:0]        TOUT_C   = 8'(TOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ACK  = 3'd2,
        S_MISS = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // Lowest-index region whose address window and qualifiers match; bit SELW is the hit flag.
    function automatic logic [SELW:0] first_hit(input logic [AW-1:0] a, input logic [1:0] c);
        logic [SELW:0] res;
        res = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) &&
                ((c & QMASK[i*2 +: 2]) == (QVAL[i*2 +: 2] & QMASK[i*2 +: 2]))) begin
                res = {1'b1, SELW'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Wait-state count configured for a region.
    function automatic logic [WSW-1:0] ws_of(input logic [SELW-1:0] idx);
        return WS[int'(idx)*WSW +: WSW];
    endfunction

    // Active-low one-cold chip-select pattern for a region.
    function automatic logic [NREG-1:0] cs_of(input logic [SELW-1:0] idx);
        return ~(NREG'(1) << idx);
    endfunction

    state_t          state_q, state_d;
    logic [WSW-1:0]  cnt_q, cnt_d;
    logic [7:0]      tcnt_q, tcnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            rw_q, rw_d;
    logic [1:0]      wdat_q, wdat_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic            as_prev_q, as_prev_d;
    logic [NREG-1:0] cs_n_q, cs_n_d;
    logic            rdy_q, rdy_d;
    logic            berr_q, berr_d;

    logic            start_s;
    logic [SELW:0]   hit_s;
    logic            din_unused_s;

    assign start_s      = ~AS & as_prev_q & (state_q == S_IDLE);
    assign hit_s        = first_hit(ADDR, ctrl_q);
    assign din_unused_s = ^DIN[7:2];

    assign CS_N = cs_n_q;
    assign RDY  = rdy_q;
    assign BERR = berr_q;
    assign CTRL = ctrl_q;

    // Next-state, counter, latch and registered-output computation for the access FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        sel_d     = sel_q;
        rw_d      = rw_q;
        wdat_d    = wdat_q;
        ctrl_d    = ctrl_q;
        as_prev_d = AS;
        cs_n_d    = '1;
        rdy_d     = 1'b0;
        berr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    rw_d   = RW;
                    wdat_d = DIN[1:0];
                    if (hit_s[SELW]) begin
                        state_d = S_WAIT;
                        sel_d   = hit_s[SELW-1:0];
                        cnt_d   = ws_of(hit_s[SELW-1:0]);
                        cs_n_d  = cs_of(hit_s[SELW-1:0]);
                    end else begin
                        state_d = S_MISS;
                        tcnt_d  = 8'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (AS) begin
                    state_d = S_HOLD;
                end else if (cnt_q == '0) begin
                    state_d = S_ACK;
                    cs_n_d  = cs_of(sel_q);
                    rdy_d   = 1'b1;
                    if (!rw_q && (sel_q == CTRL_SEL)) begin
                        ctrl_d = wdat_q;
                    end else begin
                        ctrl_d = ctrl_q;
                    end
                end else begin
                    cnt_d  = cnt_q - {{(WSW-1){1'b0}}, 1'b1};
                    cs_n_d = cs_of(sel_q);
                end
            end
            S_ACK: begin
                if (AS) begin
                    state_d = S_HOLD;
                end else begin
                    cs_n_d = cs_of(sel_q);
                    rdy_d  = 1'b1;
                end
            end
            S_MISS: begin
                if (AS) begin
                    state_d = S_HOLD;
                end else begin
                    if (tcnt_q != TOUT_C) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end else begin
                        tcnt_d = tcnt_q;
                    end
                    berr_d = (tcnt_d == TOUT_C);
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tcnt_d  = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, latched access attributes and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tcnt_q    <= 8'd0;
            sel_q     <= '0;
            rw_q      <= 1'b1;
            wdat_q    <= 2'b00;
            ctrl_q    <= CTRL_INIT;
            as_prev_q <= 1'b0;
            cs_n_q    <= '1;
            rdy_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            sel_q     <= sel_d;
            rw_q      <= rw_d;
            wdat_q    <= wdat_d;
            ctrl_q    <= ctrl_d;
            as_prev_q <= as_prev_d;
            cs_n_q    <= cs_n_d;
            rdy_q     <= rdy_d;
            berr_q    <= berr_d;
        end
    end

endmodule

// File: tb/tb_addr_decode_ws.sv
// Self-checking bench for addr_decode_ws with default parameters.
// Each access is described by its expected trace: chip-select pattern, first RDY
// cycle, first BERR cycle and resulting CTRL; cycle k counts from the cycle AS
// is first driven low, and every cycle's outputs are compared.
module tb_addr_decode_ws;

    logic        CLK = 1'b0;
    logic        RST;
    logic        AS;
    logic        RW;
    logic [15:0] ADDR;
    logic [7:0]  DIN;
    logic [3:0]  CS_N;
    logic        RDY;
    logic        BERR;
    logic [1:0]  CTRL;

    int errors = 0;
    int checks = 0;
    logic [1:0] model_ctrl;

    localparam int TOUT = 15;
    localparam logic [15:0] M_BASE [4] = '{16'h8000, 16'h2000, 16'h2000, 16'h5C00};
    localparam logic [15:0] M_MASK [4] = '{16'h8000, 16'hE000, 16'hE000, 16'hFC00};
    localparam logic [1:0]  M_QM   [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [1:0]  M_QV   [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
    localparam int          M_WS   [4] = '{0, 0, 1, 2};

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  din;
        int          n;
        logic [3:0]  cs;
        int          rdy_first;
        int          berr_first;
        logic [1:0]  ctrl;
    } vec_t;

    vec_t tbl [15];

    addr_decode_ws dut (
        .CLK  (CLK),
        .RST  (RST),
        .AS   (AS),
        .RW   (RW),
        .ADDR (ADDR),
        .DIN  (DIN),
        .CS_N (CS_N),
        .RDY  (RDY),
        .BERR (BERR),
        .CTRL (CTRL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int k, input logic [3:0] ecs,
                         input logic erdy, input logic eberr, input logic [1:0] ectrl);
        checks++;
        if ({CS_N, RDY, BERR, CTRL} !== {ecs, erdy, eberr, ectrl}) begin
            errors++;
            $display("FAIL %s cycle %0d: got cs_n=%b rdy=%b berr=%b ctrl=%b, want cs_n=%b rdy=%b berr=%b ctrl=%b",
                     name, k, CS_N, RDY, BERR, CTRL, ecs, erdy, eberr, ectrl);
        end
    endtask

    // AS low during cycles 0..n-1, high for gap cycles afterwards.
    task automatic run_access(input logic [15:0] addr, input logic rw, input logic [7:0] din,
                              input int n, input int gap, input logic [3:0] cs, input int rdy_first,
                              input int berr_first, input logic [1:0] ctrl_end, input string name);
        logic [1:0] c0;
        logic       acked;
        c0    = model_ctrl;
        acked = (rdy_first != 0) && (rdy_first <= n);
        for (int k = 0; k < n + gap; k++) begin
            @(negedge CLK);
            check(name, k,
                  (k >= 1 && k <= n) ? cs : 4'hF,
                  (rdy_first != 0 && k >= rdy_first && k <= n),
                  (berr_first != 0 && k >= berr_first && k <= n),
                  (acked && k >= rdy_first) ? ctrl_end : c0);
            AS = (k < n) ? 1'b0 : 1'b1;
            if (k == 0) begin
                ADDR = addr;
                RW   = rw;
                DIN  = din;
            end else begin
                ADDR = 16'($urandom);
                RW   = 1'($urandom);
                DIN  = 8'($urandom);
            end
        end
        if (acked) model_ctrl = ctrl_end;
    endtask

    function automatic int model_hit(input logic [15:0] a, input logic [1:0] c);
        for (int i = 0; i < 4; i++) begin
            if ((a & M_MASK[i]) == M_BASE[i] && (c & M_QM[i]) == (M_QV[i] & M_QM[i])) return i;
        end
        return -1;
    endfunction

    initial begin
        tbl[0]  = '{16'h9000, 1'b1, 8'h00, 4,  4'b1110, 2, 0,  2'b00};
        tbl[1]  = '{16'h2100, 1'b1, 8'h00, 5,  4'b1011, 3, 0,  2'b00};
        tbl[2]  = '{16'h5C00, 1'b0, 8'h01, 6,  4'b0111, 4, 0,  2'b01};
        tbl[3]  = '{16'h2100, 1'b1, 8'h00, 4,  4'b1101, 2, 0,  2'b01};
        tbl[4]  = '{16'h5C10, 1'b1, 8'h00, 5,  4'b0111, 4, 0,  2'b01};
        tbl[5]  = '{16'h1000, 1'b1, 8'h00, 18, 4'b1111, 0, 16, 2'b01};
        tbl[6]  = '{16'h1000, 1'b1, 8'h00, 15, 4'b1111, 0, 16, 2'b01};
        tbl[7]  = '{16'h1000, 1'b1, 8'h00, 16, 4'b1111, 0, 16, 2'b01};
        tbl[8]  = '{16'h5C00, 1'b0, 8'h02, 3,  4'b0111, 4, 0,  2'b01};
        tbl[9]  = '{16'h5C00, 1'b0, 8'hFE, 4,  4'b0111, 4, 0,  2'b10};
        tbl[10] = '{16'h2100, 1'b1, 8'h00, 5,  4'b1011, 3, 0,  2'b10};
        tbl[11] = '{16'h9000, 1'b0, 8'h03, 3,  4'b1110, 2, 0,  2'b10};
        tbl[12] = '{16'h5C00, 1'b1, 8'h03, 5,  4'b0111, 4, 0,  2'b10};
        tbl[13] = '{16'h5C00, 1'b0, 8'h00, 4,  4'b0111, 4, 0,  2'b00};
        tbl[14] = '{16'h9000, 1'b1, 8'h00, 1,  4'b1110, 2, 0,  2'b00};

        RST = 1'b1; AS = 1'b1; RW = 1'b1; ADDR = 16'h0000; DIN = 8'h00;
        model_ctrl = 2'b00;
        repeat (2) @(negedge CLK);
        check("reset", 0, 4'hF, 1'b0, 1'b0, 2'b00);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Directed vectors.
        for (int i = 0; i < 15; i++) begin
            run_access(tbl[i].addr, tbl[i].rw, tbl[i].din, tbl[i].n, 2 + (i % 2),
                       tbl[i].cs, tbl[i].rdy_first, tbl[i].berr_first, tbl[i].ctrl, $sformatf("vec%0d", i));
        end

        // Reset during WAIT with AS held low through release.
        run_access(16'h5C00, 1'b0, 8'h01, 4, 2, 4'b0111, 4, 0, 2'b01, "pre_rst");
        @(negedge CLK);
        AS = 1'b0; ADDR = 16'h5C10; RW = 1'b1;
        @(negedge CLK);
        check("rst_wait", 1, 4'b0111, 1'b0, 1'b0, 2'b01);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_out", 2, 4'hF, 1'b0, 1'b0, 2'b00);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("rst_as_low", k, 4'hF, 1'b0, 1'b0, 2'b00);
        end
        AS = 1'b1;
        model_ctrl = 2'b00;
        run_access(16'h9000, 1'b1, 8'h00, 3, 2, 4'b1110, 2, 0, 2'b00, "post_rst");

        // Randomized accesses against the decode rules.
        for (int t = 0; t < 60; t++) begin
            logic [15:0] a;
            logic        rw;
            logic [7:0]  d;
            int          h;
            int          n;
            int          sel;
            sel = $urandom_range(0, 4);
            a = 16'($urandom);
            case (sel)
                0: a = a | 16'h8000;
                1: a = 16'h2000 | (a & 16'h1FFF);
                2: a = 16'h5C00 | (a & 16'h03FF);
                3: a = a;
                default: a = 16'h1000 | (a & 16'h0FFF);
            endcase
            rw = 1'($urandom);
            d  = 8'($urandom);
            h  = model_hit(a, model_ctrl);
            if (h >= 0) begin
                n = $urandom_range(1, M_WS[h] + 4);
                run_access(a, rw, d, n, $urandom_range(2, 4), ~(4'b0001 << h), M_WS[h] + 2, 0,
                           (h == 3 && !rw) ? d[1:0] : model_ctrl, "rand_hit");
            end else begin
                n = $urandom_range(1, TOUT + 4);
                run_access(a, rw, d, n, $urandom_range(2, 4), 4'hF, 0, TOUT + 1, model_ctrl, "rand_miss");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
